// File: rtl/fc_ctrl_pkg.sv
// Shared types and constants for the FC classifier controller.
// State encoding, datapath geometry, class codes and error bit positions.
package fc_ctrl_pkg;

   localparam int LANES     = 4;
   localparam int DW        = 8;
   localparam int NUM_BEATS = 16;

   localparam logic [1:0] CLASS_NORMAL   = 2'd0;
   localparam logic [1:0] CLASS_ABNORMAL = 2'd1;

   localparam int ERR_TIMEOUT    = 0;
   localparam int ERR_START_DROP = 1;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT,
      HOLD,
      CLEAR
   } fc_state_t;

endpackage

// File: rtl/fc_sequencer_rd_lat_pipe.sv
// Read-latency delay line: tracks buffer read strobes for DEPTH cycles
// and registers the returning word so it leaves aligned with its valid bit.
module rd_lat_pipe
   import fc_ctrl_pkg::*;
#(
   parameter int DEPTH = 1,
   parameter int W     = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   output logic [W-1:0] out_data
);

   logic [DEPTH-1:0] vld_sr;

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_sr    <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         vld_sr[0] <= in_valid;
         for (int i = 1; i < DEPTH; i++)
            vld_sr[i] <= vld_sr[i-1];
         // data is zeroed outside the beat window
         out_valid <= vld_sr[DEPTH-1];
         out_data  <= vld_sr[DEPTH-1] ? in_data : '0;
      end
   end

endmodule

// File: rtl/fc_sequencer.sv
// Controller for the 4-lane FC classifier: streams the feature buffer
// into the FC datapath, captures the class and hands it downstream.
module fc_sequencer
   import fc_ctrl_pkg::*;
#(
   parameter int LANES     = fc_ctrl_pkg::LANES,
   parameter int DW        = fc_ctrl_pkg::DW,
   parameter int NUM_BEATS = fc_ctrl_pkg::NUM_BEATS,
   parameter int AW        = 4,
   parameter int RD_LAT    = 1,
   parameter int TIMEOUT   = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   output logic                busy,
   output logic                buf_rd,
   output logic [AW-1:0]       buf_addr,
   input  logic [LANES*DW-1:0] buf_data,
   output logic                fc_en,
   output logic [LANES*DW-1:0] fc_in,
   input  logic                fc_flag,
   input  logic [1:0]          fc_class,
   output logic                res_valid,
   output logic [1:0]          res_class,
   input  logic                res_ready,
   output logic [1:0]          err
);

   localparam int CW = $clog2(NUM_BEATS + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [CW-1:0] NB   = CW'(NUM_BEATS);
   localparam logic [CW-1:0] LAST = CW'(NUM_BEATS - 1);
   localparam logic [TW-1:0] TO   = TW'(TIMEOUT);

   fc_state_t state, state_nx;

   logic [CW-1:0]       rd_cnt;
   logic [CW-1:0]       beat_cnt;
   logic [TW-1:0]       wait_cnt;
   logic                pipe_vld;
   logic [LANES*DW-1:0] pipe_data;

   rd_lat_pipe #(
      .DEPTH (RD_LAT),
      .W     (LANES*DW)
   ) u_pipe (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (buf_rd),
      .in_data   (buf_data),
      .out_valid (pipe_vld),
      .out_data  (pipe_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rd_cnt    <= '0;
         beat_cnt  <= '0;
         wait_cnt  <= '0;
         res_class <= CLASS_NORMAL;
         err       <= '0;
      end else begin
         state <= state_nx;

         if (state != FETCH)
            rd_cnt <= '0;
         else if (buf_rd)
            rd_cnt <= rd_cnt + CW'(1);

         if (state != FETCH)
            beat_cnt <= '0;
         else if (pipe_vld)
            beat_cnt <= beat_cnt + CW'(1);

         if (state != WAIT)
            wait_cnt <= '0;
         else
            wait_cnt <= wait_cnt + TW'(1);

         if (state == WAIT && fc_flag)
            res_class <= fc_class;

         if (start && state != IDLE)
            err[ERR_START_DROP] <= 1'b1;

         if (state == WAIT && !fc_flag && wait_cnt == TO)
            err[ERR_TIMEOUT] <= 1'b1;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:  if (start) state_nx = FETCH;
         FETCH: if (pipe_vld && beat_cnt == LAST) state_nx = WAIT;
         WAIT: begin
            if (fc_flag)
               state_nx = HOLD;
            else if (wait_cnt == TO)
               state_nx = CLEAR;
         end
         HOLD:  if (res_ready) state_nx = CLEAR;
         CLEAR: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // enable tracks the beat window, then holds so the FC keeps its flag
   assign busy      = (state != IDLE);
   assign buf_rd    = (state == FETCH) && (rd_cnt < NB);
   assign buf_addr  = buf_rd ? AW'(rd_cnt) : '0;
   assign fc_in     = pipe_data;
   assign fc_en     = pipe_vld || state == WAIT || state == HOLD;
   assign res_valid = (state == HOLD);

endmodule

// File: tb/tb_fc_sequencer.sv
// Bench for fc_sequencer: buffer model, reference FC stub, and a
// scoreboard of expected beats and classes.
module tb_fc_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        busy;
   logic        buf_rd;
   logic [3:0]  buf_addr;
   logic [31:0] buf_data;
   logic        fc_en;
   logic [31:0] fc_in;
   logic        fc_flag;
   logic [1:0]  fc_class;
   logic        res_valid;
   logic [1:0]  res_class;
   logic        res_ready = 1'b0;
   logic [1:0]  err;

   int n_chk = 0;
   int n_err = 0;

   logic [31:0] beat_q[$];
   logic [1:0]  cls_q[$];

   logic [31:0] mem [16];
   logic [31:0] rdata = '0;

   int fc_cnt = 0;
   int fc_acc = 0;
   bit fc_stuck = 1'b0;

   always #5 clk = ~clk;

   fc_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .busy      (busy),
      .buf_rd    (buf_rd),
      .buf_addr  (buf_addr),
      .buf_data  (buf_data),
      .fc_en     (fc_en),
      .fc_in     (fc_in),
      .fc_flag   (fc_flag),
      .fc_class  (fc_class),
      .res_valid (res_valid),
      .res_class (res_class),
      .res_ready (res_ready),
      .err       (err)
   );

   function automatic int lane_sum(input logic [31:0] w);
      int s = 0;
      for (int i = 0; i < 4; i++)
         s += int'($signed(w[i*8 +: 8]));
      return s;
   endfunction

   function automatic logic [1:0] golden_class();
      int s = 0;
      for (int k = 0; k < 16; k++)
         s += lane_sum(mem[k]);
      return (2032 - 8*s >= -2032 + 8*s) ? 2'd0 : 2'd1;
   endfunction

   // buffer with one cycle of read latency
   always @(posedge clk)
      if (buf_rd) rdata <= mem[buf_addr];
   assign buf_data = rdata;

   // reference FC: accumulates enabled beats, flags after the 16th
   always @(posedge clk) begin
      if (!fc_en) begin
         fc_cnt <= 0;
         fc_acc <= 0;
      end else if (fc_cnt < 16) begin
         fc_cnt <= fc_cnt + 1;
         fc_acc <= fc_acc + lane_sum(fc_in);
      end
   end
   assign fc_flag  = (fc_cnt == 16) && !fc_stuck;
   assign fc_class = (2032 - 8*fc_acc >= -2032 + 8*fc_acc) ? 2'd0 : 2'd1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_buf_rd"}, buf_rd, 0);
      chk({tag, "_buf_addr"}, buf_addr, 0);
      chk({tag, "_fc_en"}, fc_en, 0);
      chk({tag, "_fc_in"}, fc_in, 0);
      chk({tag, "_res_valid"}, res_valid, 0);
      chk({tag, "_res_class"}, res_class, 0);
      chk({tag, "_err"}, err, 0);
   endtask

   task automatic run(input int rdy_dly, input bit restart, input bit stuck);
      int  acc_at;
      int  ce = -1;
      int  en_cnt = 0;
      int  n_res = 0;
      int  n_vld = 0;
      bit  done = 1'b0;
      beat_q.delete();
      cls_q.delete();
      for (int k = 0; k < 16; k++) beat_q.push_back(mem[k]);
      cls_q.push_back(golden_class());
      fc_stuck = stuck;
      acc_at = 20 + rdy_dly;
      res_ready = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c < 70; c++) begin
         start = restart && (c == 5);
         res_ready = !stuck && (c >= acc_at);
         if (c <= 16) begin
            chk("buf_rd", buf_rd, 1);
            chk("buf_addr", buf_addr, c - 1);
         end else if (c == 17) begin
            chk("buf_rd_end", buf_rd, 0);
         end
         if (c == 2) begin
            chk("fc_en_pre", fc_en, 0);
            chk("fc_in_pre", fc_in, 0);
         end
         if (c >= 3 && c <= 18) begin
            chk("fc_en_beat", fc_en, 1);
            if (beat_q.size() > 0) chk("fc_in", fc_in, beat_q.pop_front());
         end
         if (c == 19) chk("fc_in_post", fc_in, 0);
         if (fc_en && !fc_flag && c <= 19) en_cnt++;
         if (res_valid) n_vld++;
         if (res_valid && res_ready) n_res++;
         if (restart && c == 6) chk("err_start_drop", err[1], 1);
         if (!stuck) begin
            if (c == 19) begin
               chk("en_beats", en_cnt, 16);
               chk("res_valid_early", res_valid, 0);
            end
            if (c >= 20 && c <= acc_at) begin
               chk("res_valid", res_valid, 1);
               chk("hold_fc_en", fc_en, 1);
               if (c < acc_at && cls_q.size() > 0)
                  chk("res_class_hold", res_class, cls_q[0]);
               else if (cls_q.size() > 0)
                  chk("res_class", res_class, cls_q.pop_front());
            end
            if (c == acc_at + 1) begin
               chk("clear_fc_en", fc_en, 0);
               chk("clear_res_valid", res_valid, 0);
               chk("clear_busy", busy, 1);
            end
            if (c == acc_at + 2) begin
               chk("idle_busy", busy, 0);
               done = 1'b1;
               break;
            end
         end else begin
            if (c == 45) chk("err_to_early", err[0], 0);
            if (ce < 0 && err[0]) begin
               ce = c;
               chk("to_clear_fc_en", fc_en, 0);
               chk("to_clear_busy", busy, 1);
            end else if (ce > 0 && c == ce + 1) begin
               chk("to_idle_busy", busy, 0);
               done = 1'b1;
               break;
            end
         end
         tick();
      end
      chk("run_done", done, 1);
      res_ready = 1'b0;
      if (stuck) begin
         chk("to_cycle", (ce >= 51 && ce <= 53), 1);
         chk("to_no_result", n_vld, 0);
         fc_stuck = 1'b0;
      end else begin
         chk("one_result", n_res, 1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < 16; k++) mem[k] = '0;
      repeat (3) tick();
      chk_idle("reset");
      rst = 1'b0;
      tick();
      chk_idle("post_reset");

      run(0, 1'b0, 1'b0);
      chk("zeros_class", res_class, 0);

      for (int k = 0; k < 16; k++) mem[k] = {4{8'(k)}};
      run(0, 1'b0, 1'b0);
      chk("ramp_class", res_class, 1);

      for (int k = 0; k < 16; k++) mem[k] = $urandom;
      run(10, 1'b0, 1'b0);

      for (int k = 0; k < 16; k++) mem[k] = $urandom;
      run(0, 1'b1, 1'b0);
      chk("err_sticky", err[1], 1);

      for (int k = 0; k < 16; k++) mem[k] = $urandom;
      run(0, 1'b0, 1'b0);

      run(0, 1'b0, 1'b1);
      chk("err_to_sticky", err[0], 1);

      for (int k = 0; k < 16; k++) mem[k] = $urandom;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c < 10; c++) tick();
      chk("abort_beat7", fc_in, mem[7]);
      rst = 1'b1;
      tick();
      chk_idle("abort");
      rst = 1'b0;
      tick();

      for (int k = 0; k < 16; k++) mem[k] = 32'h7f7f_7f7f ^ $urandom;
      run(3, 1'b0, 1'b0);
      chk("after_abort_err", err, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/fc_sequencer.md
Name: fc_sequencer

Overview:
- Controller for the 4-lane fully-connected classifier stage.
- On `start` from the upstream feature buffer, reads `NUM_BEATS` words of `LANES` x `DW`-bit features from the buffer and streams one word per cycle into the FC datapath while holding its enable.
- Waits for the FC completion flag and captures the class.
- Presents the class on a valid/ready result port, then drops the FC enable for one cycle so the datapath re-initialises its accumulators for the next inference.

Parameters:
- `LANES`, 4, features per beat.
- `DW`, 8, bits per feature (signed).
- `NUM_BEATS`, 16, beats per inference.
- `AW`, 4, buffer address width; must satisfy 2^AW >= `NUM_BEATS`.
- `RD_LAT`, 1, buffer read latency in cycles (1..3).
- `TIMEOUT`, 32, maximum cycles in WAIT before abort.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle pulse: feature buffer full.
- `busy`  out  1  high in every state except IDLE.
- `buf_rd`  out  1  buffer read strobe.
- `buf_addr`  out  `AW`  buffer read address.
- `buf_data`  in  `LANES*DW`  read data, valid `RD_LAT` cycles after `buf_rd`.
- `fc_en`  out  1  FC datapath enable; low clears the FC accumulators.
- `fc_in`  out  `LANES*DW`  FC input word; lane i is at bits [i*DW +: DW].
- `fc_flag`  in  1  FC result valid.
- `fc_class`  in  2  FC class (0 = normal, 1 = abnormal).
- `res_valid`  out  1  result valid.
- `res_class`  out  2  captured class.
- `res_ready`  in  1  downstream accepts the result.
- `err`  out  2  sticky error flags: [0] timeout, [1] start dropped.

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0, read-latency pipe cleared.
- Reset asserted mid-operation:
  - Next cycle everything is at reset values.
  - `fc_en` = 0 therefore clears the FC datapath; no result is emitted for the aborted inference.
- State machine:
  - IDLE -> FETCH when `start` = 1.
  - FETCH -> WAIT after beat `NUM_BEATS-1` has been presented on `fc_in`.
  - WAIT -> HOLD when `fc_flag` = 1.
  - WAIT -> CLEAR when the WAIT counter reaches `TIMEOUT`.
  - HOLD -> CLEAR on `res_valid && res_ready`.
  - CLEAR -> IDLE unconditionally after 1 cycle.
- FETCH, read side:
  - `buf_rd` = 1 for exactly `NUM_BEATS` consecutive cycles.
  - `buf_addr` = 0,1,...,`NUM_BEATS-1`; no wrap, no repeat.
- FETCH, feed side:
  - Each `buf_data` word is registered into `fc_in` one cycle after arrival.
  - `fc_en` rises in the same cycle beat 0 appears on `fc_in`.
  - `fc_en` stays high continuously through FETCH, WAIT and HOLD; the FC must see exactly `NUM_BEATS` enabled cycles of valid data before its flag.
  - `fc_in` = 0 outside the beat window.
- Latency, with `start` seen at cycle T:
  - `buf_rd` high T+1..T+`NUM_BEATS`.
  - `fc_in` beat k at T+2+`RD_LAT`+k.
  - WAIT entered at T+2+`RD_LAT`+`NUM_BEATS`.
- WAIT:
  - When `fc_flag` is seen, `fc_class` is captured into `res_class` and `res_valid` = 1 on the next cycle.
  - Against the reference FC model (flag one cycle after the last beat), `res_valid` rises at T+19+`RD_LAT` (T+20 for defaults).
- HOLD:
  - `res_valid` and `res_class` stay stable until accepted.
  - `fc_en` is held high to preserve the FC flag.
- CLEAR: `fc_en` = 0, `res_valid` = 0, `busy` = 1.
- `start` while `busy`:
  - Ignored; `err[1]` set.
  - `start` in the same cycle as the CLEAR -> IDLE transition is also dropped.
- Timeout:
  - The WAIT counter starts at 0 on entry.
  - If `fc_flag` is not seen by count `TIMEOUT`, `err[0]` is set and the FSM goes to CLEAR; no result is emitted.
- `err` bits are sticky; cleared only by `rst`.
- `fc_flag` outside WAIT is ignored.

Decomposition:
- Shared package `fc_ctrl_pkg` holds:
  - State enum: IDLE, FETCH, WAIT, HOLD, CLEAR.
  - Constants `LANES`, `DW`, `NUM_BEATS`.
  - Class constants CLASS_NORMAL = 0, CLASS_ABNORMAL = 1.
  - Error bit indices ERR_TIMEOUT = 0, ERR_START_DROP = 1.
- Sub-module `rd_lat_pipe`: parameterised valid/data delay line of depth `RD_LAT`, cleared by `rst`. It aligns `buf_data` with its valid bit.

Test Plan:
- Buffer all zeros, `start` at T, `res_ready` = 1:
  - `buf_addr` 0..15 at T+1..T+16.
  - `fc_en` high from T+3.
  - `res_valid` = 1 at T+20 with `res_class` = 0, since quant1 = 2032 >= quant2 = -2032.
  - `fc_en` low exactly one cycle at T+21, then `busy` = 0.
- Buffer word k = {k,k,k,k} -> `fc_in` shows beat k at T+3+k.
  - Exactly 16 enabled beats before `fc_flag`.
  - `res_class` matches the golden FC model.
- `res_ready` held 0 for 10 cycles after `res_valid`:
  - `res_valid`, `res_class` and `fc_en` stay stable.
  - Accepted on the first `res_ready` = 1, then CLEAR.
- `start` pulsed again at T+5:
  - Ignored; `err[1]` = 1.
  - Exactly one result emitted.
  - A later `start` after IDLE runs normally.
- Stub FC that never asserts `fc_flag`, `TIMEOUT` = 32:
  - `err[0]` = 1 when the WAIT counter reaches 32.
  - One CLEAR cycle, then IDLE; `res_valid` never asserted.
- `rst` asserted at beat 7 of FETCH:
  - Next cycle all outputs are 0 and `fc_en` = 0.
  - A subsequent `start` yields the correct result with no residue from the aborted run.
